nonce_dispatcher: RTL

Job scheduler that shares one mining job's nonce range across `NUM_CORES` SHA-256 hash cores. It sits between the processor's MMIO job interface and the hash-core array. It hands out one nonce per issue to idle cores in round-robin order, tracks which nonce each core holds, and stops on the first golden hit. After all in-flight hashes drain, it reports a single result to the processor over a valid/ready handshake.

---
 rtl/nonce_dispatcher.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: splits one mining job's nonce range across NUM_CORES hash
// cores. Nonces go out one per cycle, round-robin, to idle cores. Issuing stops
// at the first golden hit or when the range is used up. Once every in-flight
// hash has drained, a single result is held on a valid/ready port.
// Optional feature: define NONCE_DISPATCH_ABORT_EN to add the job_abort input.
module nonce_dispatcher #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [NONCE_W-1:0]   job_start,
    input  logic [NONCE_W-1:0]   job_end,
`ifdef NONCE_DISPATCH_ABORT_EN
    input  logic                 job_abort,
`endif
    input  logic [NUM_CORES-1:0] core_ready,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NONCE_W-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_hit,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 result_found,
    output logic [NONCE_W-1:0]   result_nonce,
    output logic                 busy
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_REPORT} state_t;

    state_t                 state_q, state_d;
    logic [NONCE_W-1:0]     next_q, next_d;
    logic [NONCE_W-1:0]     end_q, end_d;
    logic                   hit_q, hit_d;
    logic [NONCE_W-1:0]     hit_nonce_q, hit_nonce_d;
    logic [NUM_CORES-1:0]   inflight_q, inflight_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NONCE_W-1:0]     tag_q [NUM_CORES];
    logic [NONCE_W-1:0]     tag_d [NUM_CORES];
    logic                   job_ready_q, job_ready_d;
    logic                   busy_q, busy_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_found_q, res_found_d;
    logic [NONCE_W-1:0]     res_nonce_q, res_nonce_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       issue_idx;
    logic                   issue_any;
    logic                   hit_found;

    // Round-robin pick: first eligible core after the last issued index.
    always_comb begin
        eligible  = core_ready & ~inflight_q;
        rr_idx    = last_q;
        issue_idx = '0;
        issue_any = 1'b0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (rr_idx == IDX_W'(NUM_CORES - 1)) begin
                rr_idx = '0;
            end else begin
                rr_idx = rr_idx + IDX_W'(1);
            end
            if (!issue_any && eligible[rr_idx]) begin
                issue_any = 1'b1;
                issue_idx = rr_idx;
            end
        end
    end

    // Next-state, completion tracking and issue outputs.
    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        end_d       = end_q;
        hit_d       = hit_q;
        hit_nonce_d = hit_nonce_q;
        inflight_d  = inflight_q;
        last_d      = last_q;
        tag_d       = tag_q;
        core_start  = '0;
        core_nonce  = '0;
        hit_found   = 1'b0;

        // Completions retire in any state; the lowest-index new hit wins.
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (core_done[i] && inflight_q[i]) begin
                inflight_d[i] = 1'b0;
                if (core_hit[i] && !hit_q && !hit_found) begin
                    hit_found   = 1'b1;
                    hit_nonce_d = tag_q[i];
                end
            end
        end
        if (hit_found) begin
            hit_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    next_d  = job_start;
                    end_d   = job_end;
                    hit_d   = 1'b0;
                    last_d  = IDX_W'(NUM_CORES - 1);
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
`ifdef NONCE_DISPATCH_ABORT_EN
                if (job_abort) begin
                    state_d = S_DRAIN;
                end else
`endif
                begin
                    if (issue_any) begin
                        core_start        = NUM_CORES'(1) << issue_idx;
                        core_nonce        = next_q;
                        inflight_d        = inflight_d | (NUM_CORES'(1) << issue_idx);
                        tag_d[issue_idx]  = next_q;
                        last_d            = issue_idx;
                        next_d            = next_q + NONCE_W'(1);
                        if (next_q == end_q) begin
                            state_d = S_DRAIN;
                        end
                    end
                    if (hit_found) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        job_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        res_valid_d = (state_d == S_REPORT);
        res_found_d = (state_d == S_REPORT) && hit_d;
        res_nonce_d = ((state_d == S_REPORT) && hit_d) ? hit_nonce_d : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            next_q      <= '0;
            end_q       <= '0;
            hit_q       <= 1'b0;
            hit_nonce_q <= '0;
            inflight_q  <= '0;
            last_q      <= IDX_W'(NUM_CORES - 1);
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                tag_q[i] <= '0;
            end
            job_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_nonce_q <= '0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            end_q       <= end_d;
            hit_q       <= hit_d;
            hit_nonce_q <= hit_nonce_d;
            inflight_q  <= inflight_d;
            last_q      <= last_d;
            tag_q       <= tag_d;
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_found_q <= res_found_d;
            res_nonce_q <= res_nonce_d;
        end
    end

    assign job_ready    = job_ready_q;
    assign busy         = busy_q;
    assign result_valid = res_valid_q;
    assign result_found = res_found_q;
    assign result_nonce = res_nonce_q;

endmodule
